// File: rtl/tri_plat_crd_rcv.sv
// rtl/tri_plat_crd_rcv.sv - credit-returning receive FIFO at the end of a tri_plat staged path
`ifndef NCLK_WIDTH
`define NCLK_WIDTH 2
`endif

module tri_plat_crd_rcv #(
    parameter int WIDTH  = 1,
    parameter int OFFSET = 0,
    parameter int DEPTH  = 4
) (
    inout  wire                               vd,
    inout  wire                               gd,
    input  logic [0:`NCLK_WIDTH-1]            nclk,
    input  logic                              flush,
    input  logic                              in_val,
    input  logic [OFFSET:OFFSET+WIDTH-1]      in_data,
    output logic                              out_val,
    output logic [OFFSET:OFFSET+WIDTH-1]      out_data,
    input  logic                              out_take,
    output logic                              crd_rtn,
    output logic [$clog2(DEPTH+1)-1:0]        occ,
    output logic                              err_ovf
);
    localparam int OW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + 2);
    localparam logic [OW-1:0] DEPTH_O  = OW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    logic clk;
    logic rst;
    assign clk = nclk[0];
    assign rst = nclk[1];

    // Power pins and spare clock bits carry no logic.
    wire unused_ok = &{1'b0, vd, gd, nclk};

    logic [OFFSET:OFFSET+WIDTH-1] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [PW-1:0] pend;

    logic          pop;
    logic          push;
    logic          ovf;
    logic [PW-1:0] discard;
    logic [PW-1:0] pend_next;
    logic [OW-1:0] occ_next;
    logic [AW-1:0] rd_ptr_inc;
    logic [AW-1:0] wr_ptr_inc;

    assign out_val  = (occ != '0) & ~flush;
    assign out_data = mem[rd_ptr];
    assign crd_rtn  = (pend != '0);

    assign pop  = out_take & out_val;
    // A full FIFO can still accept when the head leaves the same cycle.
    assign push = ~flush & in_val & ((occ != DEPTH_O) | pop);
    assign ovf  = ~flush & in_val & (occ == DEPTH_O) & ~pop;

    assign discard   = PW'(occ) + PW'(in_val);
    assign pend_next = pend - PW'(pend != '0) + PW'(pop) + (flush ? discard : '0);
    assign occ_next  = occ + OW'(push) - OW'(pop);

    assign rd_ptr_inc = (rd_ptr == LAST_PTR) ? '0 : rd_ptr + AW'(1);
    assign wr_ptr_inc = (wr_ptr == LAST_PTR) ? '0 : wr_ptr + AW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pend    <= '0;
            err_ovf <= 1'b0;
        end else begin
            pend <= pend_next;
            if (ovf) begin
                err_ovf <= 1'b1;
            end
            if (flush) begin
                occ    <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                occ <= occ_next;
                if (pop) begin
                    rd_ptr <= rd_ptr_inc;
                end
                if (push) begin
                    wr_ptr <= wr_ptr_inc;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_tri_plat_crd_rcv.sv
// tb/tb_tri_plat_crd_rcv.sv - directed bench for tri_plat_crd_rcv (DEPTH=4, WIDTH=4)
module tb_tri_plat_crd_rcv;
    logic       clk;
    logic       rst;
    logic       flush;
    logic       in_val;
    logic [0:3] in_data;
    logic       out_val;
    logic [0:3] out_data;
    logic       out_take;
    logic       crd_rtn;
    logic [2:0] occ;
    logic       err_ovf;
    wire        vd = 1'b1;
    wire        gd = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int crd_cnt;

    logic [3:0] fill_a [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
    logic [3:0] pop_b  [4] = '{4'hB, 4'hC, 4'hD, 4'hE};
    logic [3:0] fill_c [4] = '{4'h5, 4'h6, 4'h7, 4'h8};

    tri_plat_crd_rcv #(.WIDTH(4), .OFFSET(0), .DEPTH(4)) dut (
        .vd(vd),
        .gd(gd),
        .nclk({clk, rst}),
        .flush(flush),
        .in_val(in_val),
        .in_data(in_data),
        .out_val(out_val),
        .out_data(out_data),
        .out_take(out_take),
        .crd_rtn(crd_rtn),
        .occ(occ),
        .err_ovf(err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic t, input logic f);
        in_val   = v;
        in_data  = d;
        out_take = t;
        flush    = f;
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("rst_occ", 32'(occ), 0);
        check("rst_out_val", 32'(out_val), 0);
        check("rst_crd", 32'(crd_rtn), 0);
        check("rst_err", 32'(err_ovf), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // async reset clears state between edges
        drive(1'b1, 4'hA, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("one_occ", 32'(occ), 1);
        check("one_out_val", 32'(out_val), 1);
        rst = 1'b1;
        #1;
        check("async_occ", 32'(occ), 0);
        check("async_out_val", 32'(out_val), 0);
        rst = 1'b0;
        #1;

        // fill then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_a[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("fill_occ", 32'(occ), 4);
        check("fill_data", 32'(out_data), 32'hA);
        check("fill_crd", 32'(crd_rtn), 0);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 4'h0, k < 4, 1'b0);
            #1;
            if (k < 4) check("drain_data", 32'(out_data), 32'(fill_a[k]));
            check("drain_crd", 32'(crd_rtn), (k >= 1 && k <= 4) ? 1 : 0);
            tick();
        end
        check("drain_occ", 32'(occ), 0);

        // push and pop at full, pointers wrap
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_a[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 4'hE, 1'b1, 1'b0);
        #1;
        check("full_pp_head", 32'(out_data), 32'hA);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("full_pp_occ", 32'(occ), 4);
        check("full_pp_err", 32'(err_ovf), 0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 4'h0, 1'b1, 1'b0);
            #1;
            check("wrap_data", 32'(out_data), 32'(pop_b[k]));
            tick();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        tick();
        check("wrap_occ", 32'(occ), 0);
        check("wrap_crd_idle", 32'(crd_rtn), 0);

        // flush with occ=3, arriving beat and take
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 1), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 4'h3, 1'b1, 1'b1);
        #1;
        check("flush_out_val", 32'(out_val), 0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("flush_occ", 32'(occ), 0);
        for (int k = 0; k < 6; k++) begin
            check("flush_crd", 32'(crd_rtn), (k < 4) ? 1 : 0);
            tick();
        end

        // overflow is sticky and the extra beat is dropped
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_c[i], 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("ovf_err", 32'(err_ovf), 1);
        check("ovf_occ", 32'(occ), 4);
        check("ovf_head", 32'(out_data), 32'h5);
        crd_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 4'h0, k < 4, 1'b0);
            #1;
            if (k < 4) check("ovf_data", 32'(out_data), 32'(fill_c[k]));
            crd_cnt += int'(crd_rtn);
            tick();
        end
        check("ovf_crd_total", 32'(crd_cnt), 4);
        check("ovf_drain_occ", 32'(occ), 0);
        drive(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("ovf_err_sticky", 32'(err_ovf), 1);
        check("empty_flush_crd", 32'(crd_rtn), 0);

        // reset mid-drain with occ=2, pend=2
        rst = 1'b1;
        #1;
        check("rst2_err", 32'(err_ovf), 0);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 4), 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 4'h7, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 4'(i + 8), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        check("mid_occ", 32'(occ), 2);
        check("mid_crd", 32'(crd_rtn), 1);
        check("mid_data", 32'(out_data), 32'h8);
        rst = 1'b1;
        #1;
        check("mid_rst_occ", 32'(occ), 0);
        check("mid_rst_out_val", 32'(out_val), 0);
        check("mid_rst_crd", 32'(crd_rtn), 0);
        rst = 1'b0;
        crd_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            crd_cnt += int'(crd_rtn);
        end
        check("post_rst_crd", 32'(crd_cnt), 0);
        check("post_rst_occ", 32'(occ), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
